// File: rtl/fifo_word_packer.sv
// Packs NUM_BYTES consecutive FIFO bytes (first byte in lane 0) into one word on a
// valid/ready port; a flush emits the partial word with a lane-keep mask.
module fifo_word_packer #(
   parameter int NUM_BYTES = 4,
   parameter int BYTE_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fifo_empty,
   output logic                        fifo_rd_en,
   input  logic [BYTE_W-1:0]           fifo_data,
   input  logic                        flush,
   output logic [NUM_BYTES*BYTE_W-1:0] word_data,
   output logic [NUM_BYTES-1:0]        word_keep,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic [15:0]                 words_out
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_BYTES);

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

   state_t                      state, state_nx;
   logic [CW-1:0]               cnt, cnt_nx, cnt_landed;
   logic                        inflight, inflight_nx;
   logic                        flush_pending, flush_pending_nx;
   logic [NUM_BYTES*BYTE_W-1:0] data_nx;
   logic [NUM_BYTES-1:0]        keep_nx;
   logic [15:0]                 words_nx;

   // Popped bytes plus the one in flight never exceed a word, so a landing byte always has a lane.
   always_comb begin
      fifo_rd_en = !rst && (state == FILL) && !fifo_empty && !flush_pending &&
                   ((cnt + CW'(inflight)) < FULL_CNT);
   end

   always_comb begin
      state_nx         = state;
      cnt_nx           = cnt;
      cnt_landed       = cnt;
      inflight_nx      = fifo_rd_en;
      flush_pending_nx = flush_pending;
      data_nx          = word_data;
      keep_nx          = word_keep;
      words_nx         = words_out;
      word_valid       = (state == HOLD);

      case (state)
         FILL: begin
            if (inflight) begin
               for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                  if (cnt == CW'(i)) data_nx[i*BYTE_W +: BYTE_W] = fifo_data;
               end
               cnt_landed = cnt + CW'(1);
            end
            cnt_nx = cnt_landed;

            if (cnt_landed == FULL_CNT) begin
               state_nx         = HOLD;
               keep_nx          = '1;
               flush_pending_nx = 1'b0;
            end else if (flush_pending && !inflight && (cnt != '0)) begin
               state_nx = HOLD;
               for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                  keep_nx[i] = (CW'(i) < cnt);
               end
            end else if (flush && ((cnt != '0) || inflight)) begin
               flush_pending_nx = 1'b1;
            end
         end

         HOLD: begin
            if (word_ready) begin
               state_nx         = FILL;
               cnt_nx           = '0;
               flush_pending_nx = 1'b0;
               data_nx          = '0;
               words_nx         = words_out + 16'd1;
            end
         end

         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FILL;
         cnt           <= '0;
         inflight      <= 1'b0;
         flush_pending <= 1'b0;
         word_data     <= '0;
         word_keep     <= '0;
         words_out     <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         inflight      <= inflight_nx;
         flush_pending <= flush_pending_nx;
         word_data     <= data_nx;
         word_keep     <= keep_nx;
         words_out     <= words_nx;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: ideal FIFO model, acceptance monitor and per-scenario tasks
// comparing accepted words against byte-stream chunking computed by the bench.
module tb_fifo_word_packer;

   localparam int NB = 4;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [7:0]    fifo_data = '0;
   logic          flush = 1'b0;
   logic [31:0]   word_data;
   logic [3:0]    word_keep;
   logic          word_valid;
   logic          word_ready = 1'b1;
   logic [15:0]   words_out;

   int checks = 0;
   int failures = 0;
   int exp_words = 0;

   fifo_word_packer #(.NUM_BYTES(NB), .BYTE_W(BW)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_data(fifo_data), .flush(flush), .word_data(word_data), .word_keep(word_keep),
      .word_valid(word_valid), .word_ready(word_ready), .words_out(words_out)
   );

   always #5 clk = ~clk;

   // Ideal FIFO: bytes written by the tasks, read one cycle after a pop request.
   logic [7:0] mem [0:4095];
   int  wr_ptr = 0;
   int  rd_ptr = 0;
   bit  fake_nonempty = 1'b0;
   assign fifo_empty = fake_nonempty ? 1'b0 : (wr_ptr == rd_ptr);

   int  cyc = 0, pops_seen = 0, illegal_pops = 0, pops_in_hold = 0, valid_cycles = 0;
   bit  pop_now = 1'b0;
   int  pop_cycles[$];
   logic [31:0] got_data[$];
   logic [3:0]  got_keep[$];

   // Sample 2 time units after the falling edge: inputs settled, well before the next rising edge.
   always begin
      @(negedge clk);
      #2;
      cyc++;
      pop_now = 1'b0;
      if (fifo_rd_en) begin
         if (fifo_empty) illegal_pops++;
         else begin
            pop_now = 1'b1;
            pops_seen++;
            pop_cycles.push_back(cyc);
         end
         if (word_valid) pops_in_hold++;
      end
      if (word_valid) valid_cycles++;
      if (word_valid && word_ready) begin
         got_data.push_back(word_data);
         got_keep.push_back(word_keep);
      end
   end

   always @(posedge clk) begin
      if (pop_now) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic wait_words(input int n, input int budget, output bit ok);
      ok = 1'b1;
      while (got_data.size() < n) begin
         if (budget == 0) begin
            ok = 1'b0;
            return;
         end
         budget--;
         @(negedge clk);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fake_nonempty = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      fake_nonempty = 1'b0;
      exp_words = 0;
      #1;
      checks++;
      if (word_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b expected 0", word_valid);
      end
      checks++;
      if (word_keep !== 4'h0) begin
         failures++;
         $display("FAIL reset_keep: got %h expected 0", word_keep);
      end
      checks++;
      if (words_out !== 16'd0) begin
         failures++;
         $display("FAIL reset_words_out: got %0d expected 0", words_out);
      end
      checks++;
      if (word_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0", word_data);
      end
   endtask

   task automatic test_full_word();
      int  gb, pb, vb;
      bit  ok;
      word_ready = 1'b1;
      @(negedge clk);
      gb = got_data.size();
      pb = pop_cycles.size();
      vb = valid_cycles;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      wait_words(gb + 1, 40, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_word_timeout: got %0d words expected 1", got_data.size() - gb);
      end else begin
         checks++;
         if (got_data[gb] !== 32'h44332211 || got_keep[gb] !== 4'hf) begin
            failures++;
            $display("FAIL full_word_data: got %h/%h expected 44332211/f", got_data[gb], got_keep[gb]);
         end
      end
      exp_words++;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL full_word_count: got %0d expected %0d", words_out, exp_words);
      end
      checks++;
      if (valid_cycles - vb != 1) begin
         failures++;
         $display("FAIL full_word_valid_len: got %0d expected 1", valid_cycles - vb);
      end
      checks++;
      if (pop_cycles.size() - pb != 4 || pop_cycles[pop_cycles.size()-1] - pop_cycles[pb] != 3) begin
         failures++;
         $display("FAIL full_word_pops: got %0d pops expected 4 consecutive", pop_cycles.size() - pb);
      end
   endtask

   task automatic test_backpressure();
      int  gb, hb, budget;
      bit  ok, bad;
      logic [31:0] last;
      gb = got_data.size();
      hb = pops_in_hold;
      word_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      budget = 40;
      while (!word_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (!word_valid) begin
         failures++;
         $display("FAIL bp_valid_timeout: got %b expected 1", word_valid);
      end
      bad = 1'b0;
      last = word_data;
      repeat (10) begin
         @(negedge clk);
         if (word_data !== 32'h04030201 || word_keep !== 4'hf || word_valid !== 1'b1) begin
            bad = 1'b1;
            last = word_data;
         end
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL bp_hold_stable: got %h expected 04030201", last);
      end
      checks++;
      if (pops_in_hold != hb) begin
         failures++;
         $display("FAIL bp_no_pop_in_hold: got %0d pops expected 0", pops_in_hold - hb);
      end
      word_ready = 1'b1;
      wait_words(gb + 2, 60, ok);
      @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_timeout: got %0d words expected 2", got_data.size() - gb);
      end else begin
         checks++;
         if (got_data[gb] !== 32'h04030201 || got_data[gb+1] !== 32'h08070605) begin
            failures++;
            $display("FAIL bp_words: got %h,%h expected 04030201,08070605", got_data[gb], got_data[gb+1]);
         end
      end
      exp_words += 2;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL bp_count: got %0d expected %0d", words_out, exp_words);
      end
   endtask

   task automatic test_partial_flush();
      int gb;
      bit ok;
      gb = got_data.size();
      push_byte(8'hAA); push_byte(8'hBB);
      repeat (6) @(negedge clk);
      pulse_flush();
      wait_words(gb + 1, 30, ok);
      @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL partial_timeout: got 0 words expected 1");
      end else begin
         checks++;
         if (got_data[gb] !== 32'h0000BBAA || got_keep[gb] !== 4'b0011) begin
            failures++;
            $display("FAIL partial_word: got %h/%b expected 0000bbaa/0011", got_data[gb], got_keep[gb]);
         end
      end
      exp_words++;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL partial_count: got %0d expected %0d", words_out, exp_words);
      end
   endtask

   task automatic test_flush_inflight();
      int gb, pb, budget;
      bit ok;
      gb = got_data.size();
      pb = pops_seen;
      push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
      budget = 30;
      while (pops_seen < pb + 3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      pulse_flush();
      push_byte(8'hDD);
      wait_words(gb + 1, 30, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL inflight_timeout: got 0 words expected 1");
      end else begin
         checks++;
         if (got_data[gb] !== 32'h00CCBBAA || got_keep[gb] !== 4'b0111) begin
            failures++;
            $display("FAIL inflight_word: got %h/%b expected 00ccbbaa/0111", got_data[gb], got_keep[gb]);
         end
      end
      checks++;
      if (pops_seen - pb != 3) begin
         failures++;
         $display("FAIL inflight_no_extra_pop: got %0d pops expected 3", pops_seen - pb);
      end
      exp_words++;
      repeat (4) @(negedge clk);
      pulse_flush();
      wait_words(gb + 2, 30, ok);
      @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_byte_timeout: got %0d words expected 2", got_data.size() - gb);
      end else begin
         checks++;
         if (got_data[gb+1] !== 32'h000000DD || got_keep[gb+1] !== 4'b0001) begin
            failures++;
            $display("FAIL single_byte_word: got %h/%b expected 000000dd/0001", got_data[gb+1], got_keep[gb+1]);
         end
      end
      exp_words++;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL inflight_count: got %0d expected %0d", words_out, exp_words);
      end
   endtask

   task automatic test_empty_flush_and_reset();
      int gb, pb, budget;
      bit ok;
      gb = got_data.size();
      repeat (3) @(negedge clk);
      pulse_flush();
      repeat (10) @(negedge clk);
      checks++;
      if (got_data.size() != gb || word_valid !== 1'b0) begin
         failures++;
         $display("FAIL empty_flush: got %0d words valid=%b expected 0 words", got_data.size() - gb, word_valid);
      end
      pb = pops_seen;
      push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3);
      budget = 30;
      while (pops_seen < pb + 3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_words = 0;
      repeat (10) @(negedge clk);
      checks++;
      if (got_data.size() != gb || word_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_midop: got %0d words valid=%b expected 0 words", got_data.size() - gb, word_valid);
      end
      checks++;
      if (words_out !== 16'd0) begin
         failures++;
         $display("FAIL reset_midop_count: got %0d expected 0", words_out);
      end
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      wait_words(gb + 1, 40, ok);
      @(negedge clk);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL clean_word_timeout: got 0 words expected 1");
      end else begin
         checks++;
         if (got_data[gb] !== 32'h04030201 || got_keep[gb] !== 4'hf) begin
            failures++;
            $display("FAIL clean_word: got %h/%h expected 04030201/f", got_data[gb], got_keep[gb]);
         end
      end
      exp_words++;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL clean_count: got %0d expected %0d", words_out, exp_words);
      end
   endtask

   task automatic test_random_stream();
      int gb, n, pushed, budget, n_words, len;
      bit ok;
      logic [7:0]  bytes[$];
      logic [31:0] exp_d;
      logic [3:0]  exp_k;
      gb = got_data.size();
      n = int'($urandom_range(60, 120));
      pushed = 0;
      budget = 4000;
      while (pushed < n && budget > 0) begin
         @(negedge clk);
         budget--;
         word_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) != 0 && (wr_ptr - rd_ptr) < 8) begin
            bytes.push_back(8'($urandom));
            push_byte(bytes[pushed]);
            pushed++;
         end
      end
      word_ready = 1'b1;
      repeat (20) @(negedge clk);
      pulse_flush();
      n_words = (n + NB - 1) / NB;
      wait_words(gb + n_words, 100, ok);
      @(negedge clk);
      checks++;
      if (!ok || got_data.size() - gb != n_words) begin
         failures++;
         $display("FAIL rand_word_count: got %0d expected %0d", got_data.size() - gb, n_words);
      end else begin
         for (int w = 0; w < n_words; w++) begin
            len = (n - w * NB < NB) ? n - w * NB : NB;
            exp_d = '0;
            for (int j = 0; j < len; j++) exp_d = exp_d | (32'(bytes[w*NB+j]) << (8 * j));
            exp_k = 4'((1 << len) - 1);
            checks++;
            if (got_data[gb+w] !== exp_d || got_keep[gb+w] !== exp_k) begin
               failures++;
               $display("FAIL rand_word[%0d]: got %h/%b expected %h/%b", w, got_data[gb+w], got_keep[gb+w], exp_d, exp_k);
            end
         end
      end
      exp_words += n_words;
      checks++;
      if (words_out !== 16'(exp_words)) begin
         failures++;
         $display("FAIL rand_count: got %0d expected %0d", words_out, exp_words);
      end
      checks++;
      if (illegal_pops != 0 || pops_in_hold != 0) begin
         failures++;
         $display("FAIL pop_rules: got %0d empty pops %0d hold pops expected 0", illegal_pops, pops_in_hold);
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_backpressure();
      test_partial_flush();
      test_flush_inflight();
      test_empty_flush_and_reset();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
